// File: rtl/udp_echo_buf.sv
// udp_echo_buf: single-frame UDP payload echo buffer.
// Received payload bytes are stored, up to MAX_LEN of them. When the frame
// completes, the stored payload is sent back through the UDP transmit
// handshake: a udp_tx_en pulse, then one byte per udp_tx_req.
// Optional feature macro: UDP_ECHO_STATS_EN builds the saturating
// echo/drop frame counters. Without it, both counters read as constant 0.
module udp_echo_buf #(
  parameter int MAX_LEN = 1472,
  parameter int AW      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_rx_data_vld,
  input  logic [7:0]  udp_rx_data,
  input  logic        udp_rx_done,
  input  logic        tx_rdy,
  input  logic        udp_tx_req,
  output logic        udp_tx_en,
  output logic [15:0] udp_tx_data_num,
  output logic [7:0]  udp_tx_data,
  output logic        busy,
  output logic [15:0] echo_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_RDY,
    SEND
  } state_t;

  // The counters are one bit wider than the address, so that a count of
  // exactly 2**AW is representable.
  localparam logic [AW:0] MAX_CNT = (AW + 1)'(MAX_LEN);

  state_t      state;
  logic [7:0]  buffer [0:(2**AW)-1];
  logic [AW:0] wr_cnt;
  logic [AW:0] rd_cnt;

  logic        wr_fire;
  logic [AW:0] wr_cnt_next;
  logic        rd_fire;
  logic        rd_last;

  // Write strobe, byte count including any write in this cycle, and the
  // conditions for a read and for the end of a frame.
  always_comb begin
    // NOTE: every signal gets a value first; otherwise a path that leaves one unassigned infers a latch.
    wr_fire     = 1'b0;
    wr_cnt_next = wr_cnt;
    rd_fire     = 1'b0;
    rd_last     = 1'b0;
    if ((state == IDLE) || (state == RECV)) begin
      wr_fire     = udp_rx_data_vld && (wr_cnt < MAX_CNT);
      wr_cnt_next = wr_cnt + (AW + 1)'(wr_fire);
    end
    if (state == SEND) begin
      rd_fire = udp_tx_req && (16'(rd_cnt) < udp_tx_data_num);
      rd_last = (16'(rd_cnt) == udp_tx_data_num);
    end
  end

  // Payload storage. Writes happen only while receiving.
  // NOTE: the buffer has no reset. This lets it map onto block RAM, and a stale byte is never read before it is rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buffer[wr_cnt[AW-1:0]] <= udp_rx_data;
    end
  end

  // Frame sequencing: receive, wait for the transmitter, stream the buffer back.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state           <= IDLE;
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      udp_tx_en       <= 1'b0;
      udp_tx_data_num <= '0;
      udp_tx_data     <= '0;
    end else begin
      udp_tx_en <= 1'b0;
      case (state)
        IDLE, RECV: begin
          wr_cnt <= wr_cnt_next;
          if (udp_rx_done) begin
            if (wr_cnt_next == '0) begin
              state <= IDLE;
            end else begin
              udp_tx_data_num <= 16'(wr_cnt_next);
              state           <= WAIT_RDY;
            end
          end else if (wr_fire) begin
            state <= RECV;
          end
        end
        WAIT_RDY: begin
          if (tx_rdy) begin
            udp_tx_en <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (rd_fire) begin
            udp_tx_data <= buffer[rd_cnt[AW-1:0]];
            rd_cnt      <= rd_cnt + 1'b1;
          end else if (rd_last) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef UDP_ECHO_STATS_EN
  logic echo_fire;
  logic drop_fire;

  assign echo_fire = (state == WAIT_RDY) && tx_rdy;
  assign drop_fire = udp_rx_done && ((state == WAIT_RDY) || (state == SEND));

  // Saturating frame counters. The echo count advances on the same edge that raises udp_tx_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (echo_fire && (echo_cnt != 16'hFFFF)) echo_cnt <= echo_cnt + 1'b1;
      if (drop_fire && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign echo_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_echo_buf.sv
// Directed testbench for udp_echo_buf. Expected values are hand-derived.
module tb_udp_echo_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        udp_rx_data_vld = 1'b0;
  logic [7:0]  udp_rx_data = '0;
  logic        udp_rx_done = 1'b0;
  logic        tx_rdy = 1'b1;
  logic        udp_tx_req = 1'b0;
  logic        udp_tx_en;
  logic [15:0] udp_tx_data_num;
  logic [7:0]  udp_tx_data;
  logic        busy;
  logic [15:0] echo_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int en_pulses = 0;
  int exp_echo = 0;
  int exp_drop = 0;
  int en_mark;
  logic [7:0] frame [0:1599];

  udp_echo_buf dut (
    .clk            (clk),
    .rst            (rst),
    .udp_rx_data_vld(udp_rx_data_vld),
    .udp_rx_data    (udp_rx_data),
    .udp_rx_done    (udp_rx_done),
    .tx_rdy         (tx_rdy),
    .udp_tx_req     (udp_tx_req),
    .udp_tx_en      (udp_tx_en),
    .udp_tx_data_num(udp_tx_data_num),
    .udp_tx_data    (udp_tx_data),
    .busy           (busy),
    .echo_cnt       (echo_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // udp_tx_en is sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) if (udp_tx_en === 1'b1) en_pulses++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then move 1 ns past it before touching signals.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_echo = 0;
    exp_drop = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef UDP_ECHO_STATS_EN
    check({tag, "_echo"}, 32'(echo_cnt), 32'(exp_echo));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
`else
    check({tag, "_echo"}, 32'(echo_cnt), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
`endif
  endtask

  // Drive frame[base +: n], then a udp_rx_done pulse.
  task automatic send_frame(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      udp_rx_data_vld = 1'b1;
      udp_rx_data     = frame[base + i];
      tick();
    end
    udp_rx_data_vld = 1'b0;
    udp_rx_done     = 1'b1;
    tick();
    udp_rx_done = 1'b0;
  endtask

  // Issue n back-to-back requests. Each byte is checked one cycle after its request.
  task automatic read_bytes(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      udp_tx_req = 1'b1;
      tick();
      check(tag, 32'(udp_tx_data), 32'(frame[base + i]));
    end
    udp_tx_req = 1'b0;
  endtask

  // With tx_rdy high, udp_tx_en is low one cycle after done and high the next.
  task automatic expect_start(input string tag, input int num);
    check({tag, "_en_early"}, 32'(udp_tx_en), 32'd0);
    tick();
    check({tag, "_en"}, 32'(udp_tx_en), 32'd1);
    check({tag, "_num"}, 32'(udp_tx_data_num), 32'(num));
    exp_echo++;
  endtask

  initial begin
    // Reset state.
    tick();
    do_reset();
    check("rst_en", 32'(udp_tx_en), 32'd0);
    check("rst_num", 32'(udp_tx_data_num), 32'd0);
    check("rst_data", 32'(udp_tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_stats("rst");

    // 4-byte echo with tx_rdy held high.
    frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
    send_frame(0, 4);
    expect_start("f4", 4);
    tick();
    check("f4_en_pulse", 32'(udp_tx_en), 32'd0);
    check("f4_busy_send", 32'(busy), 32'd1);
    read_bytes("f4_byte", 0, 4);
    tick();
    check("f4_idle", 32'(busy), 32'd0);
    check_stats("f4");

    // Empty frame: udp_rx_done with no data.
    en_mark = en_pulses;
    udp_rx_done = 1'b1;
    tick();
    udp_rx_done = 1'b0;
    check("empty_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("empty_no_en", 32'(en_pulses), 32'(en_mark));
    check("empty_busy2", 32'(busy), 32'd0);

    // 1500-byte frame is truncated to 1472 bytes.
    for (int i = 0; i < 1500; i++) frame[i] = 8'(i * 7 + 3);
    send_frame(0, 1500);
    expect_start("big", 1472);
    tick();
    read_bytes("big_byte", 0, 1472);
    udp_tx_req = 1'b1;
    tick();
    check("big_hold", 32'(udp_tx_data), 32'(frame[1471]));
    udp_tx_req = 1'b0;
    check("big_idle", 32'(busy), 32'd0);

    // Second frame arrives during SEND: it is dropped, and the first frame is echoed intact.
    do_reset();
    frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
    frame[100] = 8'h55; frame[101] = 8'h66; frame[102] = 8'h77;
    send_frame(0, 4);
    expect_start("dup", 4);
    send_frame(100, 3);
    exp_drop++;
    en_mark = en_pulses;
    read_bytes("dup_byte", 0, 4);
    check("dup_num", 32'(udp_tx_data_num), 32'd4);
    for (int i = 0; i < 5; i++) tick();
    check("dup_no_en", 32'(en_pulses), 32'(en_mark));
    check("dup_idle", 32'(busy), 32'd0);
    check_stats("dup");

    // tx_rdy low for 10 cycles after done; extra request after the last byte.
    tx_rdy = 1'b0;
    frame[200] = 8'hA1; frame[201] = 8'hB2;
    en_mark = en_pulses;
    send_frame(200, 2);
    for (int i = 0; i < 9; i++) tick();
    check("rdy_wait_no_en", 32'(en_pulses), 32'(en_mark));
    check("rdy_wait_busy", 32'(busy), 32'd1);
    tx_rdy = 1'b1;
    tick();
    check("rdy_en", 32'(udp_tx_en), 32'd1);
    check("rdy_num", 32'(udp_tx_data_num), 32'd2);
    exp_echo++;
    read_bytes("rdy_byte", 200, 2);
    udp_tx_req = 1'b1;
    tick();
    check("rdy_extra1", 32'(udp_tx_data), 32'h0000_00B2);
    tick();
    check("rdy_extra2", 32'(udp_tx_data), 32'h0000_00B2);
    udp_tx_req = 1'b0;
    check("rdy_idle", 32'(busy), 32'd0);
    check_stats("rdy");

    // Reset in SEND after 2 of 8 bytes; then a new 3-byte frame.
    for (int i = 0; i < 8; i++) frame[300 + i] = 8'(8'hC0 + i);
    send_frame(300, 8);
    expect_start("mid", 8);
    read_bytes("mid_byte", 300, 2);
    do_reset();
    check("mid_rst_en", 32'(udp_tx_en), 32'd0);
    check("mid_rst_num", 32'(udp_tx_data_num), 32'd0);
    check("mid_rst_data", 32'(udp_tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check_stats("mid_rst");
    en_mark = en_pulses;
    for (int i = 0; i < 5; i++) tick();
    check("mid_no_en", 32'(en_pulses), 32'(en_mark));
    frame[400] = 8'h5A; frame[401] = 8'hA5; frame[402] = 8'h3C;
    send_frame(400, 3);
    expect_start("post", 3);
    read_bytes("post_byte", 400, 3);
    tick();
    check("post_idle", 32'(busy), 32'd0);
    check_stats("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
